// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch stage: fetches the word at pc over a
// req/ack handshake and holds it for decode until it is accepted.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [29:0]      npc,
  input  logic             advance,
  input  logic             stall,
  output logic [29:0]      pc,
  output logic             imem_req,
  output logic [29:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   load_instr;
  logic   do_advance;

  assign imem_addr = pc;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    load_instr = 1'b0;
    do_advance = 1'b0;
    unique case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          load_instr = 1'b1;
          state_d    = VALID;
        end
      end
      VALID: begin
        if (advance && !stall) begin
          do_advance = 1'b1;
          state_d    = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      pc          <= RESET_PC[31:2];
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      icount      <= '0;
    end else begin
      state_q     <= state_d;
      // Handshake flags are registered copies of the next state's decode.
      imem_req    <= (state_d == FETCH);
      instr_valid <= (state_d == VALID);
      if (load_instr) instr <= imem_rdata;
      if (do_advance) begin
        pc     <= npc;
        icount <= icount + CNT_W'(1);
      end
    end
  end

endmodule
